// File: rtl/yolo_isif_src_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | yolo_isif_src_pkg : shared widths, entry layout and frame-check codes |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package yolo_isif_src_pkg;

  localparam int TBITS_DEF     = 32;
  localparam int TBYTE_DEF     = TBITS_DEF / 8;
  localparam int FRAME_LEN_DEF = 8;   // matches the core's column count

  // FIFO entry is packed as {last, user, strb, data}
  function automatic int entry_w(input int tbits, input int tbyte);
    return tbits + tbyte + 2;
  endfunction

  localparam int ENTRY_W = entry_w(TBITS_DEF, TBYTE_DEF);

  typedef enum logic [1:0] {
    FC_MID   = 2'd0,
    FC_GOOD  = 2'd1,
    FC_SHORT = 2'd2,
    FC_LONG  = 2'd3
  } frame_chk_e;

endpackage
`default_nettype wire

// File: rtl/yolo_isif_src_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | yolo_fwft_fifo : first-word-fall-through FIFO with registered head    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module yolo_fwft_fifo #(
  parameter int WIDTH = 38,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid
);

  localparam int           AW       = $clog2(DEPTH);
  localparam logic [AW:0]  FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             valid_q, valid_d;
  logic             pop;

  always_comb begin
    pop      = rd_en && valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_en && !pop)      count_d = count_q + 1'b1;
    else if (!wr_en && pop) count_d = count_q - 1'b1;

    // Head after this edge: the beat being written bypasses storage when it
    // is about to become the only entry, so there is never a bubble.
    valid_d = (count_d != '0);
    head_d  = '0;
    if (valid_d) begin
      if (wr_en && (rd_ptr_d == wr_ptr_q)) head_d = wr_data;
      else                                 head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
    end
  end

  assign full     = (count_q == FULL_CNT);
  assign rd_data  = head_q;
  assign rd_valid = valid_q;

endmodule
`default_nettype wire

// File: rtl/yolo_isif_src.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | yolo_isif_src : AXI-Stream to isif FIFO-read bridge with frame check  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module yolo_isif_src
  import yolo_isif_src_pkg::*;
#(
  parameter int TBITS     = TBITS_DEF,
  parameter int TBYTE     = TBYTE_DEF,
  parameter int DEPTH     = 16,
  parameter int FRAME_LEN = FRAME_LEN_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [TBITS-1:0] s_axis_tdata,
  input  logic [TBYTE-1:0] s_axis_tkeep,
  input  logic             s_axis_tlast,
  input  logic             s_axis_tuser,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  output logic [TBITS-1:0] isif_data_dout,
  output logic [TBYTE-1:0] isif_strb_dout,
  output logic             isif_last_dout,
  output logic             isif_user_dout,
  output logic             isif_empty_n,
  input  logic             isif_read,
  output logic             frame_err,
  output logic [15:0]      frame_cnt
);

  localparam int            EW        = entry_w(TBITS, TBYTE);
  localparam int            BW        = $clog2(FRAME_LEN);
  localparam logic [BW-1:0] LAST_BEAT = BW'(FRAME_LEN - 1);

  logic          fifo_full;
  logic          push;
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] head_entry;

  logic [BW-1:0] beat_cnt_q, beat_cnt_d;
  logic          frame_err_q, frame_err_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  frame_chk_e    chk;

  // tready depends only on registered fill level, never on isif_read
  assign s_axis_tready = !fifo_full && !rst;
  assign push          = s_axis_tvalid && s_axis_tready;
  assign wr_entry      = {s_axis_tlast, s_axis_tuser, s_axis_tkeep, s_axis_tdata};

  yolo_fwft_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (push),
    .wr_data  (wr_entry),
    .full     (fifo_full),
    .rd_en    (isif_read),
    .rd_data  (head_entry),
    .rd_valid (isif_empty_n)
  );

  assign {isif_last_dout, isif_user_dout, isif_strb_dout, isif_data_dout} = head_entry;

  always_comb begin
    chk = FC_MID;
    if (s_axis_tlast) chk = (beat_cnt_q == LAST_BEAT) ? FC_GOOD : FC_SHORT;
    else if (beat_cnt_q == LAST_BEAT) chk = FC_LONG;

    beat_cnt_d  = beat_cnt_q;
    frame_err_d = frame_err_q;
    frame_cnt_d = frame_cnt_q;
    if (push) begin
      case (chk)
        FC_GOOD: begin
          beat_cnt_d  = '0;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end
        FC_SHORT, FC_LONG: begin
          beat_cnt_d  = '0;
          frame_err_d = 1'b1;
        end
        default: beat_cnt_d = beat_cnt_q + 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_q  <= '0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      frame_err_q <= frame_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_err = frame_err_q;
  assign frame_cnt = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_yolo_isif_src.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_yolo_isif_src : directed + random bench with queue reference model |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_yolo_isif_src;

  localparam int DEPTH = 16;
  localparam int FL    = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_axis_tdata = '0;
  logic [3:0]  s_axis_tkeep = '0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tuser = 1'b0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [31:0] isif_data_dout;
  logic [3:0]  isif_strb_dout;
  logic        isif_last_dout;
  logic        isif_user_dout;
  logic        isif_empty_n;
  logic        isif_read = 1'b0;
  logic        frame_err;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  yolo_isif_src dut (
    .clk            (clk),
    .rst            (rst),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tkeep   (s_axis_tkeep),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tuser   (s_axis_tuser),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .isif_data_dout (isif_data_dout),
    .isif_strb_dout (isif_strb_dout),
    .isif_last_dout (isif_last_dout),
    .isif_user_dout (isif_user_dout),
    .isif_empty_n   (isif_empty_n),
    .isif_read      (isif_read),
    .frame_err      (frame_err),
    .frame_cnt      (frame_cnt)
  );

  typedef struct packed {
    logic        last;
    logic        user;
    logic [3:0]  strb;
    logic [31:0] data;
  } beat_t;

  // Reference model: queue contents, frame position, sticky error, frame count
  beat_t       q[$];
  int          m_beat = 0;
  logic        m_err  = 1'b0;
  logic [15:0] m_fcnt = '0;
  bit          m_zero = 1'b1;
  bit          last_push = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("tready", 64'(s_axis_tready), 64'(!rst && (q.size() != DEPTH)));
    chk("empty_n", 64'(isif_empty_n), 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk("data", 64'(isif_data_dout), 64'(q[0].data));
      chk("strb", 64'(isif_strb_dout), 64'(q[0].strb));
      chk("last", 64'(isif_last_dout), 64'(q[0].last));
      chk("user", 64'(isif_user_dout), 64'(q[0].user));
    end else if (m_zero) begin
      chk("dout_zero", 64'({isif_last_dout, isif_user_dout, isif_strb_dout, isif_data_dout}), 64'd0);
    end
    chk("frame_err", 64'(frame_err), 64'(m_err));
    chk("frame_cnt", 64'(frame_cnt), 64'(m_fcnt));
  endtask

  task automatic model_step();
    bit push;
    bit pop;
    push = s_axis_tvalid && !rst && (q.size() != DEPTH);
    pop  = isif_read && (q.size() != 0);
    last_push = push;
    if (rst) begin
      q.delete();
      m_beat = 0;
      m_err  = 1'b0;
      m_fcnt = '0;
      m_zero = 1'b1;
      last_push = 1'b0;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back('{last: s_axis_tlast, user: s_axis_tuser, strb: s_axis_tkeep, data: s_axis_tdata});
        m_zero = 1'b0;
        if (s_axis_tlast) begin
          if (m_beat == FL - 1) m_fcnt = m_fcnt + 16'd1;
          else                  m_err  = 1'b1;
          m_beat = 0;
        end else if (m_beat == FL - 1) begin
          m_err  = 1'b1;
          m_beat = 0;
        end else begin
          m_beat = m_beat + 1;
        end
      end
    end
  endtask

  // One clock: drive on the falling edge, check settled state, advance the model
  task automatic cyc(input logic v, input logic [31:0] d, input logic [3:0] k,
                     input logic l, input logic u, input logic r, input logic rs);
    @(negedge clk);
    s_axis_tvalid = v;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tuser  = u;
    isif_read     = r;
    rst           = rs;
    #1;
    check_outputs();
    model_step();
  endtask

  task automatic idle(input int n, input logic r);
    repeat (n) cyc(1'b0, 32'd0, 4'd0, 1'b0, 1'b0, r, 1'b0);
  endtask

  task automatic do_reset();
    cyc(1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  logic        src_v = 1'b0;
  logic [31:0] src_d = '0;
  logic [3:0]  src_k = '0;
  logic        src_l = 1'b0;
  logic        src_u = 1'b0;
  int          src_idx = 0;
  int          rd_pct = 50;
  int          v_pct = 50;

  initial begin
    do_reset();
    do_reset();
    idle(1, 1'b0);
    chk("lit_rst_tready", 64'(s_axis_tready), 64'd1);
    chk("lit_rst_empty_n", 64'(isif_empty_n), 64'd0);
    chk("lit_rst_dout", 64'(isif_data_dout), 64'd0);

    // One good frame, read held high
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 32'(i), 4'hF, 1'(i == 8), 1'b0, 1'b1, 1'b0);
      if (i == 2) chk("lit_first_head", 64'(isif_data_dout), 64'd1);
    end
    idle(3, 1'b1);
    chk("lit_t1_fcnt", 64'(frame_cnt), 64'd1);
    chk("lit_t1_err", 64'(frame_err), 64'd0);

    // Fill to DEPTH, then hold a 17th beat until a slot frees
    for (int i = 1; i <= 16; i++)
      cyc(1'b1, 32'(100 + i), 4'h5, 1'(i % 8 == 0), 1'(i[0]), 1'b0, 1'b0);
    cyc(1'b1, 32'd117, 4'hA, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lit_full_tready", 64'(s_axis_tready), 64'd0);
    cyc(1'b1, 32'd117, 4'hA, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 32'd117, 4'hA, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lit_freed_tready", 64'(s_axis_tready), 64'd1);
    idle(20, 1'b1);

    // Read while empty
    idle(3, 1'b1);
    chk("lit_empty_read", 64'(isif_empty_n), 64'd0);
    cyc(1'b1, 32'd200, 4'h3, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1, 1'b0);
    chk("lit_after_empty_data", 64'(isif_data_dout), 64'd200);
    idle(2, 1'b1);
    do_reset();

    // Short frame then a good one
    for (int i = 1; i <= 5; i++)
      cyc(1'b1, 32'(300 + i), 4'hF, 1'(i == 5), 1'b0, 1'b1, 1'b0);
    idle(2, 1'b1);
    chk("lit_short_err", 64'(frame_err), 64'd1);
    chk("lit_short_fcnt", 64'(frame_cnt), 64'd0);
    for (int i = 1; i <= 8; i++)
      cyc(1'b1, 32'(310 + i), 4'hF, 1'(i == 8), 1'b0, 1'b1, 1'b0);
    idle(3, 1'b1);
    chk("lit_after_short_fcnt", 64'(frame_cnt), 64'd1);
    chk("lit_after_short_err", 64'(frame_err), 64'd1);

    // Reset with entries queued
    for (int i = 1; i <= 5; i++)
      cyc(1'b1, 32'(400 + i), 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
    idle(1, 1'b0);
    chk("lit_rst_mid_empty_n", 64'(isif_empty_n), 64'd0);
    chk("lit_rst_mid_fcnt", 64'(frame_cnt), 64'd0);
    chk("lit_rst_mid_err", 64'(frame_err), 64'd0);
    for (int i = 1; i <= 8; i++)
      cyc(1'b1, 32'(410 + i), 4'hF, 1'(i == 8), 1'b0, 1'b1, 1'b0);
    idle(3, 1'b1);
    chk("lit_rst_mid_frame", 64'(frame_cnt), 64'd1);

    // Long frame: error flagged at the 8th push
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      cyc(1'b1, 32'(500 + i), 4'hF, 1'(i == 9), 1'b0, 1'b1, 1'b0);
      if (i == 8) chk("lit_long_err_before", 64'(frame_err), 64'd0);
      if (i == 9) chk("lit_long_err_at8", 64'(frame_err), 64'd1);
    end
    idle(3, 1'b1);

    // Random traffic; source holds an offered beat until it is accepted
    for (int n = 0; n < 3000; n++) begin
      if (n % 500 == 0) begin
        rd_pct = int'($urandom_range(10, 100));
        v_pct  = int'($urandom_range(10, 100));
      end
      if (!src_v || last_push) begin
        src_v = (int'($urandom_range(99)) < v_pct);
        if (src_v) begin
          src_d = $urandom;
          src_k = 4'($urandom);
          src_u = 1'($urandom);
          src_l = (src_idx == FL - 1);
          if ($urandom_range(15) == 0) src_l = !src_l;
          src_idx = src_l ? 0 : (src_idx + 1) % FL;
        end
      end
      cyc(src_v, src_d, src_k, src_l, src_u,
          1'(int'($urandom_range(99)) < rd_pct), 1'($urandom_range(999) == 0));
    end
    idle(DEPTH + 2, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
